// File: rtl/seq_det_prog.sv
// -----------------------------------------------------------------------------
// seq_det_prog
//   Programmable serial bit-sequence detector with a Moore-style match flag.
//   Each accepted bit is shifted into a history register. A hit is flagged when
//   the newest `len` bits equal the low `len` bits of the programmed pattern.
//   The pattern, length and overlap mode can be reloaded at run time.
//
// Parameters
//   MAX_LEN  maximum pattern length in bits (>= 2)
//   CNT_W    width of the saturating match counter
//   RST_PAT  pattern after reset (low RST_LEN bits used)
//   RST_LEN  pattern length after reset
//   RST_OVL  overlap mode after reset (1 = overlapping)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   signal     in   serial data bit
//   in_valid   in   signal is sampled only when 1
//   cfg_load   in   load cfg_* this cycle (takes priority over in_valid)
//   cfg_pat    in   pattern; bit[len-1] is the first bit received, bit[0] the last
//   cfg_len    in   pattern length (0 disables detection, > MAX_LEN is clamped)
//   cfg_ovl    in   1 = overlapping matches, 0 = non-overlapping
//   out        out  match flag, held until the next accepted bit
//   match_pls  out  one-cycle pulse per detection
//   match_cnt  out  saturating detection count
//   busy_cfg   out  1 from a config load until the first accepted bit
// -----------------------------------------------------------------------------
module seq_det_prog #(
   parameter int                 MAX_LEN = 8,
   parameter int                 CNT_W   = 8,
   parameter logic [MAX_LEN-1:0] RST_PAT = 8'b0001_1011,
   parameter int                 RST_LEN = 5,
   parameter logic               RST_OVL = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           signal,
   input  logic                           in_valid,
   input  logic                           cfg_load,
   input  logic [MAX_LEN-1:0]             cfg_pat,
   input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
   input  logic                           cfg_ovl,
   output logic                           out,
   output logic                           match_pls,
   output logic [CNT_W-1:0]               match_cnt,
   output logic                           busy_cfg
);

   localparam int               LEN_W     = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] RST_LEN_L = LEN_W'(RST_LEN);

   // configuration registers
   logic [MAX_LEN-1:0] pat_r;
   logic [LEN_W-1:0]   len_r;
   logic               ovl_r;

   // detection state
   logic [MAX_LEN-1:0] hist_r;
   logic [LEN_W-1:0]   fill_r;
   logic               out_r;
   logic               pls_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               busy_r;

   // next-state helpers
   logic [MAX_LEN-1:0] hist_next_s;
   logic [LEN_W-1:0]   fill_next_s;
   logic [MAX_LEN-1:0] mask_s;
   logic               hit_s;
   logic [CNT_W-1:0]   cnt_inc_s;
   logic [LEN_W-1:0]   len_load_s;

   // History shift and saturating fill count for the bit being offered
   always_comb begin
      hist_next_s = {hist_r[MAX_LEN-2:0], signal};
      if (fill_r == MAX_LEN_L) begin
         fill_next_s = fill_r;
      end else begin
         fill_next_s = fill_r + LEN_W'(1);
      end
   end

   // Compare only the newest len bits; len == MAX_LEN shifts every one out of the mask
   always_comb begin
      mask_s = ~({MAX_LEN{1'b1}} << len_r);
      if ((len_r != {LEN_W{1'b0}}) && (fill_next_s >= len_r)) begin
         hit_s = (((hist_next_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});
      end else begin
         hit_s = 1'b0;
      end
   end

   // Saturating counter increment and clamping of the loaded length
   always_comb begin
      if (cnt_r == {CNT_W{1'b1}}) begin
         cnt_inc_s = cnt_r;
      end else begin
         cnt_inc_s = cnt_r + CNT_W'(1);
      end
      if (cfg_len > MAX_LEN_L) begin
         len_load_s = MAX_LEN_L;
      end else begin
         len_load_s = cfg_len;
      end
   end

   // Config, history and output registers; a config load discards the offered bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_r  <= RST_PAT;
         len_r  <= RST_LEN_L;
         ovl_r  <= RST_OVL;
         hist_r <= {MAX_LEN{1'b0}};
         fill_r <= {LEN_W{1'b0}};
         out_r  <= 1'b0;
         pls_r  <= 1'b0;
         cnt_r  <= {CNT_W{1'b0}};
         busy_r <= 1'b0;
      end else if (cfg_load) begin
         pat_r  <= cfg_pat;
         len_r  <= len_load_s;
         ovl_r  <= cfg_ovl;
         hist_r <= {MAX_LEN{1'b0}};
         fill_r <= {LEN_W{1'b0}};
         out_r  <= 1'b0;
         pls_r  <= 1'b0;
         busy_r <= 1'b1;
      end else if (in_valid) begin
         hist_r <= hist_next_s;
         // non-overlapping mode demands len fresh bits after every hit
         if (hit_s && !ovl_r) begin
            fill_r <= {LEN_W{1'b0}};
         end else begin
            fill_r <= fill_next_s;
         end
         out_r  <= hit_s;
         pls_r  <= hit_s;
         busy_r <= 1'b0;
         if (hit_s) begin
            cnt_r <= cnt_inc_s;
         end else begin
            cnt_r <= cnt_r;
         end
      end else begin
         // idle cycle: Moore flag holds, pulse drops
         pls_r <= 1'b0;
      end
   end

   assign out       = out_r;
   assign match_pls = pls_r;
   assign match_cnt = cnt_r;
   assign busy_cfg  = busy_r;

endmodule

// File: tb/tb_seq_det_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_det_prog
//   Directed bench for seq_det_prog. Stimulus tasks push the hand-computed
//   response for each clock cycle into a queue; a monitor pops one entry per
//   cycle and compares it with the outputs. A second instance with CNT_W=4
//   exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_seq_det_prog;

   typedef struct packed {
      logic       o;
      logic       p;
      logic       b;
      logic [7:0] c;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       signal;
   logic       in_valid;
   logic       cfg_load;
   logic [7:0] cfg_pat;
   logic [3:0] cfg_len;
   logic       cfg_ovl;
   logic       out;
   logic       match_pls;
   logic [7:0] match_cnt;
   logic       busy_cfg;

   logic       b_sig;
   logic       b_valid;
   logic       b_load;
   logic [7:0] b_pat;
   logic [3:0] b_len;
   logic       b_ovl;
   logic       b_out;
   logic       b_pls;
   logic [3:0] b_cnt;
   logic       b_busy;

   exp_t exp_q[$];
   int   n_chk;
   int   n_fail;
   int   n_cyc;
   logic exp_busy;

   seq_det_prog dut (
      .clk(clk), .rst(rst), .signal(signal), .in_valid(in_valid),
      .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
      .out(out), .match_pls(match_pls), .match_cnt(match_cnt), .busy_cfg(busy_cfg)
   );

   seq_det_prog #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .signal(b_sig), .in_valid(b_valid),
      .cfg_load(b_load), .cfg_pat(b_pat), .cfg_len(b_len), .cfg_ovl(b_ovl),
      .out(b_out), .match_pls(b_pls), .match_cnt(b_cnt), .busy_cfg(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: one expected response per stimulus cycle, sampled on the falling edge
   always @(negedge clk) begin
      exp_t e;
      if (rst && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cyc++;
         chk($sformatf("out[%0d]", n_cyc), {31'd0, out}, {31'd0, e.o});
         chk($sformatf("match_pls[%0d]", n_cyc), {31'd0, match_pls}, {31'd0, e.p});
         chk($sformatf("busy_cfg[%0d]", n_cyc), {31'd0, busy_cfg}, {31'd0, e.b});
         chk($sformatf("match_cnt[%0d]", n_cyc), {24'd0, match_cnt}, {24'd0, e.c});
      end
   end

   // one cycle of data (v=1) or idle (v=0) with the expected response
   task automatic step(input logic v, input logic s, input logic eo, input logic ep, input int ec);
      cfg_load = 1'b0;
      in_valid = v;
      signal   = s;
      if (v) exp_busy = 1'b0;
      exp_q.push_back('{o: eo, p: ep, b: exp_busy, c: 8'(ec)});
      @(posedge clk);
      @(negedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // one config-load cycle, optionally with a data bit offered at the same time
   task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov,
                      input logic v, input logic s, input int ec);
      cfg_load = 1'b1;
      cfg_pat  = p;
      cfg_len  = l;
      cfg_ovl  = ov;
      in_valid = v;
      signal   = s;
      exp_busy = 1'b1;
      exp_q.push_back('{o: 1'b0, p: 1'b0, b: 1'b1, c: 8'(ec)});
      @(posedge clk);
      @(negedge clk);
      #1;
      cfg_load = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic b_bit(input logic s);
      b_valid = 1'b1;
      b_sig   = s;
      @(posedge clk);
      #1;
      b_valid = 1'b0;
   endtask

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      n_chk = 0; n_fail = 0; n_cyc = 0; exp_busy = 1'b0;
      rst = 1'b0; signal = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
      cfg_pat = 8'd0; cfg_len = 4'd0; cfg_ovl = 1'b0;
      b_sig = 1'b0; b_valid = 1'b0; b_load = 1'b0; b_pat = 8'd0; b_len = 4'd0; b_ovl = 1'b0;

      // reset state
      #12;
      chk("rst_out", {31'd0, out}, 32'd0);
      chk("rst_pls", {31'd0, match_pls}, 32'd0);
      chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
      chk("rst_busy", {31'd0, busy_cfg}, 32'd0);
      @(negedge clk); #1; rst = 1'b1;

      // 1: default 11011 overlapping, bits 1,1,0,1,1,0,1,1
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 2);
      step(1'b0, 1'b0, 1'b1, 1'b0, 2);

      // 2: non-overlapping, same bits -> one hit
      cfg(8'b0001_1011, 4'd5, 1'b0, 1'b0, 1'b0, 2);
      step(1'b1, 1'b1, 1'b0, 1'b0, 2);
      step(1'b1, 1'b1, 1'b0, 1'b0, 2);
      step(1'b1, 1'b0, 1'b0, 1'b0, 2);
      step(1'b1, 1'b1, 1'b0, 1'b0, 2);
      step(1'b1, 1'b1, 1'b1, 1'b1, 3);
      step(1'b1, 1'b0, 1'b0, 1'b0, 3);
      step(1'b1, 1'b1, 1'b0, 1'b0, 3);
      step(1'b1, 1'b1, 1'b0, 1'b0, 3);

      // 3: gaps of three idle cycles between bits; flag held while idle
      cfg(8'b0001_1011, 4'd5, 1'b1, 1'b0, 1'b0, 3);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, (i == 2) ? 1'b0 : 1'b1, 1'b0, 1'b0, 3);
         for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 3);
      end
      step(1'b1, 1'b1, 1'b1, 1'b1, 4);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 4);
      step(1'b1, 1'b0, 1'b0, 1'b0, 4);

      // 4: cfg_load with in_valid mid-pattern discards the bit and the history
      cfg(8'b0001_1011, 4'd5, 1'b1, 1'b0, 1'b0, 4);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4);
      step(1'b1, 1'b0, 1'b0, 1'b0, 4);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4);
      cfg(8'b0001_1011, 4'd5, 1'b1, 1'b1, 1'b1, 4);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4);
      step(1'b1, 1'b0, 1'b0, 1'b0, 4);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4);
      step(1'b1, 1'b1, 1'b1, 1'b1, 5);

      // 5a: len 0 disables detection
      cfg(8'b0000_0000, 4'd0, 1'b1, 1'b0, 1'b0, 5);
      for (int i = 0; i < 64; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 5);

      // 5b: len 9 clamps to 8, pattern 10100110
      cfg(8'b1010_0110, 4'd9, 1'b1, 1'b0, 1'b0, 5);
      step(1'b1, 1'b1, 1'b0, 1'b0, 5);
      step(1'b1, 1'b0, 1'b0, 1'b0, 5);
      step(1'b1, 1'b1, 1'b0, 1'b0, 5);
      step(1'b1, 1'b0, 1'b0, 1'b0, 5);
      step(1'b1, 1'b0, 1'b0, 1'b0, 5);
      step(1'b1, 1'b1, 1'b0, 1'b0, 5);
      step(1'b1, 1'b1, 1'b0, 1'b0, 5);
      step(1'b1, 1'b0, 1'b1, 1'b1, 6);
      step(1'b1, 1'b1, 1'b0, 1'b0, 6);
      step(1'b1, 1'b0, 1'b0, 1'b0, 6);

      // 5c: len 1, pat 1 -> flag tracks each accepted bit
      cfg(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0, 6);
      step(1'b1, 1'b1, 1'b1, 1'b1, 7);
      step(1'b1, 1'b0, 1'b0, 1'b0, 7);
      step(1'b1, 1'b1, 1'b1, 1'b1, 8);
      step(1'b1, 1'b1, 1'b1, 1'b1, 9);
      step(1'b1, 1'b0, 1'b0, 1'b0, 9);

      // 6b: async reset during a partial match
      cfg(8'b0001_1011, 4'd5, 1'b1, 1'b0, 1'b0, 9);
      step(1'b1, 1'b1, 1'b0, 1'b0, 9);
      step(1'b1, 1'b1, 1'b0, 1'b0, 9);
      step(1'b1, 1'b0, 1'b0, 1'b0, 9);
      step(1'b1, 1'b1, 1'b0, 1'b0, 9);
      step(1'b1, 1'b1, 1'b1, 1'b1, 10);
      step(1'b1, 1'b0, 1'b0, 1'b0, 10);
      step(1'b1, 1'b1, 1'b0, 1'b0, 10);
      step(1'b1, 1'b1, 1'b1, 1'b1, 11);
      chk("drain_before_rst", exp_q.size(), 32'd0);
      rst = 1'b0;
      #1;
      chk("async_rst_out", {31'd0, out}, 32'd0);
      chk("async_rst_pls", {31'd0, match_pls}, 32'd0);
      chk("async_rst_cnt", {24'd0, match_cnt}, 32'd0);
      @(negedge clk); #1; rst = 1'b1;
      exp_busy = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1);

      // 6a: CNT_W=4 instance, overlapping 11011 stream, 20+3 hits
      @(negedge clk); #1;
      b_bit(1'b1);
      b_bit(1'b1);
      for (int i = 0; i < 23; i++) begin
         b_bit(1'b0);
         b_bit(1'b1);
         b_bit(1'b1);
         if (i == 13) chk("cnt4_after_14", {28'd0, b_cnt}, 32'd14);
         if (i == 19) chk("cnt4_after_20", {28'd0, b_cnt}, 32'd15);
      end
      chk("cnt4_hold", {28'd0, b_cnt}, 32'd15);
      chk("cnt4_out", {31'd0, b_out}, 32'd1);

      repeat (3) @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
